// File: rtl/axi4_stream_if.sv
// AXI4-Stream bundle: one beat of payload plus the valid/ready handshake.
// The master drives the payload and tvalid; the slave drives tready.
interface axi4_stream_if #(
   parameter int TDATA_WIDTH = 64,
   parameter int TID_WIDTH   = 1,
   parameter int TDEST_WIDTH = 1,
   parameter int TUSER_WIDTH = 1
);
   localparam int TDATA_WIDTH_B = TDATA_WIDTH / 8;

   logic                     tvalid;
   logic                     tready;
   logic [TDATA_WIDTH-1:0]   tdata;
   logic [TDATA_WIDTH_B-1:0] tkeep;
   logic [TDATA_WIDTH_B-1:0] tstrb;
   logic                     tlast;
   logic [TID_WIDTH-1:0]     tid;
   logic [TDEST_WIDTH-1:0]   tdest;
   logic [TUSER_WIDTH-1:0]   tuser;

   modport master (
      output tvalid, tdata, tkeep, tstrb, tlast, tid, tdest, tuser,
      input  tready
   );

   modport slave (
      input  tvalid, tdata, tkeep, tstrb, tlast, tid, tdest, tuser,
      output tready
   );
endinterface

// File: rtl/axi4_stream_fifo.sv
// Single-clock first-word-fall-through AXI4-Stream FIFO storing complete beats.
// Define AXI4_STREAM_FIFO_PKT_MODE_EN to hold output until a whole packet is stored.
module axi4_stream_fifo #(
   parameter int TDATA_WIDTH  = 64,
   parameter int TID_WIDTH    = 1,
   parameter int TDEST_WIDTH  = 1,
   parameter int TUSER_WIDTH  = 1,
   parameter int DEPTH        = 16,
   localparam int TDATA_WIDTH_B = TDATA_WIDTH / 8,
   localparam int ADDR_WIDTH    = $clog2(DEPTH),
   localparam int CNT_WIDTH     = ADDR_WIDTH + 1
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   axi4_stream_if.slave         pkt_i,
   axi4_stream_if.master        pkt_o,
   output logic [CNT_WIDTH-1:0] used_words_o,
   output logic                 full_o,
   output logic                 empty_o
);
   localparam int BEAT_W = TDATA_WIDTH + 2 * TDATA_WIDTH_B + 1
                         + TID_WIDTH + TDEST_WIDTH + TUSER_WIDTH;

   logic [BEAT_W-1:0]     r_mem [DEPTH];
   logic [ADDR_WIDTH-1:0] r_wr_ptr;
   logic [ADDR_WIDTH-1:0] r_rd_ptr;
   logic [CNT_WIDTH-1:0]  r_used;
   logic [BEAT_W-1:0]     w_wr_beat;
   logic [BEAT_W-1:0]     w_rd_beat;
   logic                  w_wr;
   logic                  w_rd;

   assign w_wr_beat = {pkt_i.tdata, pkt_i.tkeep, pkt_i.tstrb, pkt_i.tlast,
                       pkt_i.tid, pkt_i.tdest, pkt_i.tuser};
   assign w_rd_beat = r_mem[r_rd_ptr];
   assign {pkt_o.tdata, pkt_o.tkeep, pkt_o.tstrb, pkt_o.tlast,
           pkt_o.tid, pkt_o.tdest, pkt_o.tuser} = w_rd_beat;

   assign used_words_o = r_used;
   assign full_o       = (r_used == CNT_WIDTH'(DEPTH));
   assign empty_o      = (r_used == '0);

   // No write-through when full: the slot freed by a read is offered next cycle.
   assign pkt_i.tready = !full_o && !rst_i;
   assign w_wr         = pkt_i.tvalid && pkt_i.tready;
   assign w_rd         = pkt_o.tvalid && pkt_o.tready;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_used   <= '0;
      end else begin
         if (w_wr) begin
            r_mem[r_wr_ptr] <= w_wr_beat;
            r_wr_ptr        <= r_wr_ptr + 1'b1;
         end
         if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_wr, w_rd})
            2'b10:   r_used <= r_used + 1'b1;
            2'b01:   r_used <= r_used - 1'b1;
            default: r_used <= r_used;
         endcase
      end
   end

`ifdef AXI4_STREAM_FIFO_PKT_MODE_EN
   logic [CNT_WIDTH-1:0] r_pkt_cnt;
   logic                 r_force_out;
   logic                 w_wr_last;
   logic                 w_rd_last;

   assign w_wr_last = w_wr && pkt_i.tlast;
   assign w_rd_last = w_rd && pkt_o.tlast;

   // A packet longer than the FIFO can never complete inside it, so it is
   // released cut-through until its last beat leaves.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_pkt_cnt   <= '0;
         r_force_out <= 1'b0;
      end else begin
         case ({w_wr_last, w_rd_last})
            2'b10:   r_pkt_cnt <= r_pkt_cnt + 1'b1;
            2'b01:   r_pkt_cnt <= r_pkt_cnt - 1'b1;
            default: r_pkt_cnt <= r_pkt_cnt;
         endcase
         if (w_rd_last)
            r_force_out <= 1'b0;
         else if (full_o && (r_pkt_cnt == '0))
            r_force_out <= 1'b1;
      end
   end

   assign pkt_o.tvalid = !empty_o && ((r_pkt_cnt != '0) || r_force_out);
`else
   assign pkt_o.tvalid = !empty_o;
`endif

endmodule

// File: tb/tb_axi4_stream_fifo.sv
// Directed bench for axi4_stream_fifo with DEPTH=8: vector table plus corner sequences.
// Packet-mode sequences are compiled only when AXI4_STREAM_FIFO_PKT_MODE_EN is defined.
module tb_axi4_stream_fifo;
   localparam int DW    = 64;
   localparam int DEPTH = 8;
   localparam int CW    = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   axi4_stream_if #(.TDATA_WIDTH(DW)) s_if ();
   axi4_stream_if #(.TDATA_WIDTH(DW)) m_if ();
   logic [CW-1:0] used;
   logic          full;
   logic          empty;

   axi4_stream_fifo #(
      .TDATA_WIDTH(DW), .TID_WIDTH(1), .TDEST_WIDTH(1), .TUSER_WIDTH(1), .DEPTH(DEPTH)
   ) dut (
      .clk_i(clk), .rst_i(rst), .pkt_i(s_if), .pkt_o(m_if),
      .used_words_o(used), .full_o(full), .empty_o(empty)
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic          in_v;
      logic [63:0]   in_d;
      logic          out_r;
      logic          exp_in_r;
      logic          exp_out_v;
      logic          chk_d;
      logic [63:0]   exp_d;
      logic [CW-1:0] exp_used;
      logic          exp_full;
      logic          exp_empty;
   } vec_t;

   vec_t vecs [21];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] keep_of(input logic [63:0] d);
      return d[7:0] ^ 8'h5A;
   endfunction

   function automatic logic [63:0] beat(input int i);
      return 64'(i + 1) * 64'h9E37_79B9_7F4A_7C15;
   endfunction

   task automatic drive_in(input logic v, input logic [63:0] d, input logic last);
      s_if.tvalid = v;
      s_if.tdata  = d;
      s_if.tkeep  = keep_of(d);
      s_if.tstrb  = d[15:8];
      s_if.tlast  = last;
      s_if.tid    = d[2];
      s_if.tdest  = d[1];
      s_if.tuser  = d[0];
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [63:0] exp_q [$];
      logic [63:0] e;
      logic        do_wr;
      logic        do_rd;
      int          sent;
      int          got;
      int          cyc;

      // Fill/full/drain table, DEPTH=8, source continuously valid.
      for (int i = 0; i < 8; i++)
         vecs[i] = '{1'b1, 64'(i), 1'b0, 1'b1, (i > 0), (i > 0), 64'd0, CW'(i), 1'b0, (i == 0)};
      vecs[8]  = '{1'b1, 64'd8, 1'b0, 1'b0, 1'b1, 1'b1, 64'd0, CW'(8), 1'b1, 1'b0};
      vecs[9]  = '{1'b1, 64'd8, 1'b1, 1'b0, 1'b1, 1'b1, 64'd0, CW'(8), 1'b1, 1'b0};
      vecs[10] = '{1'b1, 64'd8, 1'b0, 1'b1, 1'b1, 1'b1, 64'd1, CW'(7), 1'b0, 1'b0};
      vecs[11] = '{1'b1, 64'd9, 1'b0, 1'b0, 1'b1, 1'b1, 64'd1, CW'(8), 1'b1, 1'b0};
      for (int k = 0; k < 8; k++)
         vecs[12 + k] = '{1'b0, 64'd0, 1'b1, (k != 0), 1'b1, 1'b1, 64'(k + 1), CW'(8 - k), (k == 0), 1'b0};
      vecs[20] = '{1'b0, 64'd0, 1'b1, 1'b1, 1'b0, 1'b0, 64'd0, CW'(0), 1'b0, 1'b1};

      drive_in(1'b0, 64'd0, 1'b0);
      m_if.tready = 1'b0;
      rst = 1'b1;
      #12;
      check("rst_in_ready", s_if.tready, 1'b0);
      check("rst_out_valid", m_if.tvalid, 1'b0);
      check("rst_used", used, 0);
      check("rst_empty", empty, 1'b1);
      check("rst_full", full, 1'b0);
      check("rst_tdata", m_if.tdata, 64'd0);
      check("rst_tkeep", m_if.tkeep, 8'd0);
      rst = 1'b0;

      // Single beat, no same-cycle bypass.
      next_cycle();
      drive_in(1'b1, 64'h0123_4567_89AB_CDEF, 1'b1);
      s_if.tkeep  = 8'hFF;
      m_if.tready = 1'b1;
      #1;
      check("sb_pre_valid", m_if.tvalid, 1'b0);
      check("sb_pre_in_ready", s_if.tready, 1'b1);
      next_cycle();
      drive_in(1'b0, 64'd0, 1'b0);
      #1;
      check("sb_valid", m_if.tvalid, 1'b1);
      check("sb_tdata", m_if.tdata, 64'h0123_4567_89AB_CDEF);
      check("sb_tkeep", m_if.tkeep, 8'hFF);
      check("sb_tid", m_if.tid, 1'b1);
      check("sb_tlast", m_if.tlast, 1'b1);
      check("sb_used", used, 1);
      next_cycle();
      #1;
      check("sb_used_after", used, 0);
      check("sb_empty_after", empty, 1'b1);
      check("sb_valid_after", m_if.tvalid, 1'b0);

      // Table-driven fill/full/drain.
      for (int i = 0; i < 21; i++) begin
         next_cycle();
         drive_in(vecs[i].in_v, vecs[i].in_d, 1'b1);
         m_if.tready = vecs[i].out_r;
         #1;
         check($sformatf("vec%0d_in_ready", i), s_if.tready, vecs[i].exp_in_r);
         check($sformatf("vec%0d_out_valid", i), m_if.tvalid, vecs[i].exp_out_v);
         check($sformatf("vec%0d_used", i), used, vecs[i].exp_used);
         check($sformatf("vec%0d_full", i), full, vecs[i].exp_full);
         check($sformatf("vec%0d_empty", i), empty, vecs[i].exp_empty);
         if (vecs[i].chk_d)
            check($sformatf("vec%0d_tdata", i), m_if.tdata, vecs[i].exp_d);
      end

      // Simultaneous wr and rd with one beat stored.
      next_cycle();
      drive_in(1'b1, 64'hAAAA_0001, 1'b1);
      m_if.tready = 1'b0;
      next_cycle();
      drive_in(1'b1, 64'hBBBB_0002, 1'b1);
      m_if.tready = 1'b1;
      #1;
      check("sim_pre_used", used, 1);
      check("sim_pre_tdata", m_if.tdata, 64'hAAAA_0001);
      next_cycle();
      drive_in(1'b0, 64'd0, 1'b0);
      m_if.tready = 1'b0;
      #1;
      check("sim_used", used, 1);
      check("sim_valid", m_if.tvalid, 1'b1);
      check("sim_tdata", m_if.tdata, 64'hBBBB_0002);
      m_if.tready = 1'b1;
      next_cycle();
      m_if.tready = 1'b0;
      #1;
      check("sim_drained", empty, 1'b1);

      // Random backpressure streaming against a queue model.
      sent = 0;
      got  = 0;
      cyc  = 0;
      next_cycle();
      while (got < 100 && cyc < 3000) begin
         if (sent < 100) drive_in(1'($urandom_range(0, 1)), beat(sent), 1'b1);
         else            drive_in(1'b0, 64'd0, 1'b0);
         m_if.tready = 1'($urandom_range(0, 1));
         #1;
         do_wr = s_if.tvalid && s_if.tready;
         do_rd = m_if.tvalid && m_if.tready;
         checks++;
         if (used > CW'(DEPTH)) begin
            errors++;
            $display("FAIL rnd_used_bound: got %0d, expected <= %0d", used, DEPTH);
         end
         if (do_rd) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL rnd_spurious_valid: got tvalid=1, expected no stored beat");
            end else begin
               e = exp_q.pop_front();
               check($sformatf("rnd%0d_tdata", got), m_if.tdata, e);
               check($sformatf("rnd%0d_tkeep", got), m_if.tkeep, keep_of(e));
               check($sformatf("rnd%0d_tstrb", got), m_if.tstrb, e[15:8]);
               check($sformatf("rnd%0d_tuser", got), m_if.tuser, e[0]);
               check($sformatf("rnd%0d_tdest", got), m_if.tdest, e[1]);
            end
            got++;
         end
         if (do_wr) begin
            exp_q.push_back(beat(sent));
            sent++;
         end
         next_cycle();
         cyc++;
      end
      check("rnd_beats_delivered", 64'(got), 64'd100);
      drive_in(1'b0, 64'd0, 1'b0);
      m_if.tready = 1'b0;

      // Asynchronous reset with five beats stored.
      for (int k = 0; k < 5; k++) begin
         next_cycle();
         drive_in(1'b1, 64'h00A0 + 64'(k), 1'b1);
      end
      next_cycle();
      drive_in(1'b0, 64'd0, 1'b0);
      #1;
      check("rm_used_before", used, 5);
      #1;
      rst = 1'b1;
      #1;
      check("rm_valid", m_if.tvalid, 1'b0);
      check("rm_used", used, 0);
      check("rm_empty", empty, 1'b1);
      check("rm_in_ready", s_if.tready, 1'b0);
      #2;
      rst = 1'b0;
      next_cycle();
      drive_in(1'b1, 64'hBEEF, 1'b1);
      m_if.tready = 1'b1;
      next_cycle();
      drive_in(1'b0, 64'd0, 1'b0);
      #1;
      check("rm_first_valid", m_if.tvalid, 1'b1);
      check("rm_first_tdata", m_if.tdata, 64'hBEEF);
      check("rm_first_used", used, 1);
      next_cycle();
      m_if.tready = 1'b0;
      #1;
      check("rm_drained", empty, 1'b1);

`ifdef AXI4_STREAM_FIFO_PKT_MODE_EN
      // Slowly written 3-beat packet is held until its last beat is stored.
      next_cycle();
      drive_in(1'b1, 64'hC0, 1'b0);
      next_cycle();
      drive_in(1'b0, 64'd0, 1'b0);
      #1;
      check("pk3_hold0", m_if.tvalid, 1'b0);
      next_cycle();
      #1;
      check("pk3_hold1", m_if.tvalid, 1'b0);
      next_cycle();
      drive_in(1'b1, 64'hC1, 1'b0);
      next_cycle();
      drive_in(1'b0, 64'd0, 1'b0);
      #1;
      check("pk3_hold2", m_if.tvalid, 1'b0);
      next_cycle();
      drive_in(1'b1, 64'hC2, 1'b1);
      #1;
      check("pk3_hold3", m_if.tvalid, 1'b0);
      next_cycle();
      drive_in(1'b0, 64'd0, 1'b0);
      m_if.tready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1;
         check($sformatf("pk3_b%0d_valid", k), m_if.tvalid, 1'b1);
         check($sformatf("pk3_b%0d_tdata", k), m_if.tdata, 64'hC0 + 64'(k));
         check($sformatf("pk3_b%0d_tlast", k), m_if.tlast, (k == 2));
         next_cycle();
      end
      #1;
      check("pk3_empty", empty, 1'b1);

      // 12-beat packet exceeds DEPTH and must stream out cut-through.
      sent = 0;
      got  = 0;
      cyc  = 0;
      next_cycle();
      while (got < 12 && cyc < 300) begin
         if (sent < 12) drive_in(1'b1, beat(sent), (sent == 11));
         else           drive_in(1'b0, 64'd0, 1'b0);
         m_if.tready = 1'b1;
         #1;
         do_wr = s_if.tvalid && s_if.tready;
         do_rd = m_if.tvalid && m_if.tready;
         if (do_rd) begin
            check($sformatf("pk12_b%0d_tdata", got), m_if.tdata, beat(got));
            check($sformatf("pk12_b%0d_tlast", got), m_if.tlast, (got == 11));
            got++;
         end
         if (do_wr) sent++;
         next_cycle();
         cyc++;
      end
      check("pk12_beats_delivered", 64'(got), 64'd12);
      drive_in(1'b0, 64'd0, 1'b0);
      m_if.tready = 1'b0;
      #1;
      check("pk12_empty", empty, 1'b1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/axi4_stream_fifo.md
Name: axi4_stream_fifo

Overview:
- Synchronous single-clock AXI4-Stream FIFO. It buffers complete beats: tdata, tkeep, tstrb, tlast, tid, tdest and tuser.
- Sits directly downstream of the stream upsizer on the wide side. It absorbs the upsizer's bursty output and decouples it from sink backpressure.
- The optional packet mode lets the sink see a packet only once that packet is fully stored.

Parameters:
- TDATA_WIDTH, 64, data width in bits; multiple of 8; must match the upsizer's TX_TDATA_WIDTH.
- TID_WIDTH, 1, tid width.
- TDEST_WIDTH, 1, tdest width.
- TUSER_WIDTH, 1, tuser width.
- DEPTH, 16, number of beats stored; power of two, at least 2.
- Derived: TDATA_WIDTH_B = TDATA_WIDTH/8; ADDR_WIDTH = $clog2(DEPTH); CNT_WIDTH = ADDR_WIDTH+1.

Ports:
- clk_i  input  1  single clock for the whole block.
- rst_i  input  1  asynchronous, active-high reset.
- pkt_i  axi4_stream_if.slave  TDATA_WIDTH/TID/TDEST/TUSER  write side, fed by the upsizer.
- pkt_o  axi4_stream_if.master  same widths  read side.
- used_words_o  output  CNT_WIDTH  beats currently stored, 0..DEPTH.
- full_o  output  1  used_words_o == DEPTH.
- empty_o  output  1  used_words_o == 0.

Behaviour:
- One clock, clk_i. Reset rst_i is asynchronous and active-high. All state is cleared on rst_i assertion, with no clock required.
- Reset values:
  - wr_ptr = 0, rd_ptr = 0, used_words_o = 0.
  - empty_o = 1, full_o = 0, pkt_o.tvalid = 0.
  - Storage array cleared to 0.
  - pkt_o.tdata/tkeep/tstrb/tlast/tid/tdest/tuser = 0.
  - pkt_i.tready = 0 while rst_i is high.
- Write side:
  - wr = pkt_i.tvalid && pkt_i.tready.
  - pkt_i.tready = !full_o && !rst_i.
  - On wr, store all sideband fields at mem[wr_ptr], then wr_ptr <= wr_ptr+1, wrapping modulo DEPTH by natural overflow of ADDR_WIDTH bits.
- Read side:
  - First-word-fall-through. pkt_o fields come combinationally from mem[rd_ptr].
  - pkt_o.tvalid = !empty_o, except in packet mode (see Optional Feature).
  - rd = pkt_o.tvalid && pkt_o.tready. On rd, rd_ptr <= rd_ptr+1 with wrap.
- Latency: a beat written on edge N is visible on pkt_o with tvalid high after edge N; minimum 1 cycle input-to-output.
- Count: used_words updates as follows:
  - +1 on wr only.
  - -1 on rd only.
  - unchanged on simultaneous wr and rd.
- Full: tready is low even if rd occurs in the same cycle; there is no write-through on full. The vacated slot is accepted on the next cycle.
- Empty: tvalid is low. A write to an empty FIFO never bypasses to the output in the same cycle.
- Simultaneous wr and rd with used_words == 1: output advances to the new beat, and used_words stays 1.
- Stability: pkt_o payload is held stable while tvalid=1 and tready=0, because rd_ptr is unchanged.
- Reset mid-packet: all stored beats are discarded. No partial packet survives reset.
- No tkeep/tlast checking; beats are passed through bit-exact.

Optional Feature:
- Macro: AXI4_STREAM_FIFO_PKT_MODE_EN.
- Defined:
  - A pkt_cnt register (CNT_WIDTH, reset 0) tracks the number of complete packets stored.
  - Increment on a wr with tlast; decrement on an rd with tlast; unchanged when both occur.
  - pkt_o.tvalid = !empty_o && (pkt_cnt != 0 || force_out).
  - force_out is set when full_o=1 and pkt_cnt==0, i.e. a packet is longer than DEPTH. It prevents deadlock by letting that packet stream out cut-through.
  - force_out clears on the rd of the beat with tlast. It resets to 0.
- Undefined: pkt_cnt and force_out are absent, and pkt_o.tvalid = !empty_o.

Test Plan:
- Single beat: after reset, write one beat {tdata=64'h0123_4567_89AB_CDEF, tkeep=8'hFF, tlast=1, tid=1} with pkt_o.tready=1 -> tvalid rises the next cycle with identical fields; used_words 1 -> 0; empty_o returns to 1.
- Fill and full: DEPTH=8, pkt_o.tready=0, source continuously valid with tdata=0..9 -> exactly 8 beats accepted, full_o=1, tready=0. Then pulse tready once -> tdata=0 read, and tdata=8 accepted on the following cycle.
- Wrap-around streaming: 100 random-backpressure beats (both sides valid/ready ~50%), DEPTH=8 -> output sequence equals input sequence, tkeep/tuser/tdest bit-exact, used_words never exceeds 8.
- Simultaneous wr and rd at used_words=1 -> used_words stays 1, and the output advances to the next beat with no bubble.
- Reset mid-operation: assert rst_i asynchronously with 5 beats stored -> tvalid=0, used_words=0, empty_o=1 immediately. After release, the first new beat is the first output.
- With AXI4_STREAM_FIFO_PKT_MODE_EN:
  - A 3-beat packet is written slowly -> tvalid stays 0 until the tlast beat is stored, then 3 beats are output back-to-back.
  - A 12-beat packet with DEPTH=8 -> force_out is asserted at full and all 12 beats are delivered in order, with no deadlock.
